// File: rtl/seq_scan_pkg.sv
// Shared types and constants for the round-robin bit-serial pattern scanner.
// Default geometry, state encoding and the round-robin pointer helper.
package seq_scan_pkg;

    localparam int N_CH_DEF    = 4;
    localparam int WORD_W_DEF  = 16;
    localparam int PAT_LEN_DEF = 3;

    localparam int CNT_W = $clog2(WORD_W_DEF + 1);
    localparam int IDX_W = $clog2(N_CH_DEF);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } scan_state_t;

    // Channel after the one just served, wrapping to 0; it becomes the new top priority.
    function automatic int rr_next(input int chan, input int n_ch);
        return ((chan + 1) >= n_ch) ? 0 : (chan + 1);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit-serial matcher: keeps the last PAT_LEN-1 bits of the current word and
// flags a match when those bits plus the incoming bit equal the pattern.
module seq_match_core #(
    parameter int PAT_LEN = 3,
    parameter int WORD_W  = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               bit_en,
    input  logic               bit_in,
    input  logic [PAT_LEN-1:0] pattern,
    output logic               match
);

    localparam int FILL_W = $clog2(WORD_W + 1);

    logic [PAT_LEN-2:0] history_r;
    logic [FILL_W-1:0]  fill_r;
    logic [PAT_LEN-1:0] window_s;

    // The window seen this cycle is the stored history with the new bit appended.
    assign window_s = {history_r, bit_in};

    // History and fill level; fill saturates once a full window has been seen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            history_r <= '0;
            fill_r    <= '0;
        end else if (clr) begin
            history_r <= '0;
            fill_r    <= '0;
        end else if (bit_en) begin
            history_r <= window_s[PAT_LEN-2:0];
            if (fill_r < FILL_W'(PAT_LEN)) begin
                fill_r <= fill_r + FILL_W'(1);
            end
        end
    end

    assign match = bit_en && (window_s == pattern) && (fill_r >= FILL_W'(PAT_LEN - 1));

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin arbiter feeding one shared bit-serial pattern counter; each
// granted word is scanned MSB-first and its match count returned via valid/ready.
module seq_scan_arbiter
    import seq_scan_pkg::*;
#(
    parameter int N_CH    = N_CH_DEF,
    parameter int WORD_W  = WORD_W_DEF,
    parameter int PAT_LEN = PAT_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cfg_enable,
    input  logic [PAT_LEN-1:0]         cfg_pattern,
    input  logic [N_CH-1:0]            req_valid,
    input  logic [N_CH*WORD_W-1:0]     req_data,
    output logic [N_CH-1:0]            req_ready,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(N_CH)-1:0]    res_chan,
    output logic [$clog2(WORD_W+1)-1:0] res_count,
    output logic                       res_hit,
    output logic                       busy
);

    localparam int CHAN_W  = $clog2(N_CH);
    localparam int COUNT_W = $clog2(WORD_W + 1);
    localparam int BIT_W   = $clog2(WORD_W);

    scan_state_t          state_r;
    scan_state_t          next_state_s;

    logic [CHAN_W-1:0]    rr_ptr_r;
    logic [CHAN_W-1:0]    chan_r;
    logic [CHAN_W-1:0]    grant_idx_s;
    logic [CHAN_W:0]      scan_sum_s;
    logic [CHAN_W-1:0]    scan_idx_s;
    logic [N_CH-1:0]      grant_s;
    logic                 grant_found_s;

    logic [WORD_W-1:0]    word_r;
    logic [WORD_W-1:0]    word_sel_s;
    logic [PAT_LEN-1:0]   pattern_r;
    logic [BIT_W-1:0]     bit_cnt_r;
    logic [COUNT_W-1:0]   count_r;
    logic [COUNT_W-1:0]   count_next_s;

    logic                 accept_s;
    logic                 shifting_s;
    logic                 last_bit_s;
    logic                 res_fire_s;
    logic                 match_s;

    logic                 res_valid_r;
    logic [CHAN_W-1:0]    res_chan_r;
    logic [COUNT_W-1:0]   res_count_r;
    logic                 res_hit_r;
    logic                 busy_r;

    // First valid channel at or above rr_ptr, wrapping past the top.
    always_comb begin
        grant_s       = '0;
        grant_idx_s   = '0;
        grant_found_s = 1'b0;
        scan_sum_s    = '0;
        scan_idx_s    = '0;
        for (int i = 0; i < N_CH; i++) begin
            scan_sum_s = {1'b0, rr_ptr_r} + (CHAN_W + 1)'(i);
            if (scan_sum_s >= (CHAN_W + 1)'(N_CH)) begin
                scan_idx_s = CHAN_W'(scan_sum_s - (CHAN_W + 1)'(N_CH));
            end else begin
                scan_idx_s = scan_sum_s[CHAN_W-1:0];
            end
            if (!grant_found_s && req_valid[scan_idx_s]) begin
                grant_found_s         = 1'b1;
                grant_s[scan_idx_s]   = 1'b1;
                grant_idx_s           = scan_idx_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Word of the granted channel.
    always_comb begin
        word_sel_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_idx_s == CHAN_W'(i)) begin
                word_sel_s = req_data[i*WORD_W +: WORD_W];
            end else begin
                word_sel_s = word_sel_s;
            end
        end
    end

    assign req_ready    = ((state_r == IDLE) && cfg_enable) ? grant_s : '0;
    assign accept_s     = |req_ready;
    assign shifting_s   = (state_r == SHIFT);
    assign last_bit_s   = shifting_s && (bit_cnt_r == '0);
    assign res_fire_s   = res_valid_r && res_ready;
    assign count_next_s = count_r + COUNT_W'(match_s);

    seq_match_core #(
        .PAT_LEN (PAT_LEN),
        .WORD_W  (WORD_W)
    ) u_match (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept_s),
        .bit_en  (shifting_s),
        .bit_in  (word_r[WORD_W-1]),
        .pattern (pattern_r),
        .match   (match_s)
    );

    // Next-state logic for IDLE -> SHIFT -> REPORT -> IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = SHIFT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_bit_s) begin
                    next_state_s = REPORT;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            REPORT: begin
                if (res_fire_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = REPORT;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State register; busy and res_valid are registered decodes of the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            busy_r      <= (next_state_s != IDLE);
            res_valid_r <= (next_state_s == REPORT);
        end
    end

    // Word capture and serialisation, match counting, result and pointer update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_r      <= '0;
            pattern_r   <= '0;
            chan_r      <= '0;
            bit_cnt_r   <= '0;
            count_r     <= '0;
            rr_ptr_r    <= '0;
            res_chan_r  <= '0;
            res_count_r <= '0;
            res_hit_r   <= 1'b0;
        end else begin
            if (accept_s) begin
                word_r    <= word_sel_s;
                pattern_r <= cfg_pattern;
                chan_r    <= grant_idx_s;
                bit_cnt_r <= BIT_W'(WORD_W - 1);
                count_r   <= '0;
            end else if (shifting_s) begin
                word_r    <= {word_r[WORD_W-2:0], 1'b0};
                bit_cnt_r <= bit_cnt_r - BIT_W'(1);
                count_r   <= count_next_s;
            end
            // The final bit's match is folded in here so the result is complete on entry to REPORT.
            if (last_bit_s) begin
                res_chan_r  <= chan_r;
                res_count_r <= count_next_s;
                res_hit_r   <= (count_next_s != '0);
            end
            if (res_fire_s) begin
                rr_ptr_r <= CHAN_W'(rr_next(int'(chan_r), N_CH));
            end
        end
    end

    assign res_valid = res_valid_r;
    assign res_chan  = res_chan_r;
    assign res_count = res_count_r;
    assign res_hit   = res_hit_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Self-checking bench for seq_scan_arbiter: vector table plus hand-written
// sequences for round-robin order, backpressure and reset mid-word.
module tb_seq_scan_arbiter;
    import seq_scan_pkg::*;

    localparam int NC = 4;
    localparam int WW = 16;
    localparam int PL = 3;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            cfg_enable;
    logic [PL-1:0]   cfg_pattern;
    logic [NC-1:0]   req_valid;
    logic [NC*WW-1:0] req_data;
    logic [NC-1:0]   req_ready;
    logic            res_valid;
    logic            res_ready;
    logic [1:0]      res_chan;
    logic [4:0]      res_count;
    logic            res_hit;
    logic            busy;

    typedef struct {
        int ch;
        int cnt;
    } exp_t;

    typedef struct {
        int          ch;
        logic [15:0] word;
        logic [2:0]  pat;
        int          cnt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_errors = 0;

    seq_scan_arbiter #(.N_CH(NC), .WORD_W(WW), .PAT_LEN(PL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_enable  (cfg_enable),
        .cfg_pattern (cfg_pattern),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_chan    (res_chan),
        .res_count   (res_count),
        .res_hit     (res_hit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called one cycle after an accept; waits for the result and scores it.
    task automatic collect();
        int   lat;
        int   stray;
        exp_t e;
        lat   = 1;
        stray = 0;
        while (!res_valid && lat < 40) begin
            if (req_ready != '0) stray++;
            tick();
            lat++;
        end
        chk("ready_during_scan", stray, 0);
        chk("latency", lat, WW + 1);
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("res_chan", res_chan, e.ch);
            chk("res_count", res_count, e.cnt);
            chk("res_hit", res_hit, (e.cnt != 0) ? 1 : 0);
        end
        if (res_ready) begin
            tick();
            chk("res_valid_drop", res_valid, 0);
        end
    endtask

    task automatic send(input int ch, input logic [15:0] w, input logic [2:0] p,
                        input int cnt, input bit drop_en);
        int   n;
        exp_t e;
        req_data[ch*WW +: WW] = w;
        cfg_pattern = p;
        req_valid = '0;
        req_valid[ch] = 1'b1;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("grant", req_ready, 1 << ch);
        e.ch  = ch;
        e.cnt = cnt;
        sb.push_back(e);
        tick();
        req_valid   = '0;
        cfg_pattern = ~p;
        if (drop_en) cfg_enable = 1'b0;
        collect();
        cfg_enable = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        exp_t e;

        vecs[0] = '{0, 16'hFFFF, 3'b111, 14};
        vecs[1] = '{0, 16'hAAAA, 3'b101, 7};
        vecs[2] = '{0, 16'h0007, 3'b111, 1};
        vecs[3] = '{1, 16'h0001, 3'b111, 0};
        vecs[4] = '{1, 16'hC000, 3'b111, 0};
        vecs[5] = '{2, 16'h5555, 3'b010, 7};
        vecs[6] = '{3, 16'h0000, 3'b000, 14};
        vecs[7] = '{3, 16'h1234, 3'b001, 3};
        vecs[8] = '{2, 16'hE000, 3'b111, 1};

        reset_n     = 1'b0;
        cfg_enable  = 1'b1;
        cfg_pattern = '0;
        req_valid   = '0;
        req_data    = '0;
        res_ready   = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_count", res_count, 0);
        chk("rst_res_hit", res_hit, 0);
        chk("rst_res_chan", res_chan, 0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].ch, vecs[i].word, vecs[i].pat, vecs[i].cnt, (i % 2) == 1);
        end

        // Round-robin with every channel requesting.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        req_data    = {4{16'hFFFF}};
        cfg_pattern = 3'b111;
        req_valid   = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (req_ready == '0 && n < 20) begin
                tick();
                n++;
            end
            chk("rr_order", req_ready, 1 << (k % 4));
            e.ch  = k % 4;
            e.cnt = 14;
            sb.push_back(e);
            tick();
            collect();
        end
        req_valid = '0;

        // Backpressure in REPORT.
        res_ready = 1'b0;
        send(2, 16'hFFFF, 3'b111, 14, 1'b0);
        req_data[0*WW +: WW] = 16'h0000;
        req_data[3*WW +: WW] = 16'h0000;
        cfg_pattern = 3'b000;
        req_valid   = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_valid", res_valid, 1);
            chk("hold_chan", res_chan, 2);
            chk("hold_count", res_count, 14);
            chk("hold_hit", res_hit, 1);
            chk("hold_no_ready", req_ready, 0);
        end
        res_ready = 1'b1;
        tick();
        chk("bp_valid_drop", res_valid, 0);
        chk("bp_next_grant", req_ready, 4'b1000);
        e.ch  = 3;
        e.cnt = 14;
        sb.push_back(e);
        tick();
        req_valid = '0;
        collect();

        // Reset in the middle of a word.
        send(1, 16'h00E0, 3'b111, 1, 1'b0);
        req_data[2*WW +: WW] = 16'hFFFF;
        cfg_pattern = 3'b111;
        req_valid   = 4'b0100;
        #1;
        n = 0;
        while (req_ready == '0 && n < 20) begin
            tick();
            n++;
        end
        chk("mid_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        for (int k = 0; k < 7; k++) tick();
        chk("mid_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_valid", res_valid, 0);
        tick();
        chk("mid_rst_busy_next", busy, 0);
        chk("mid_rst_valid_next", res_valid, 0);
        reset_n = 1'b1;
        req_data[0*WW +: WW] = 16'h0007;
        req_data[3*WW +: WW] = 16'hFFFF;
        req_valid = 4'b1001;
        #1;
        chk("post_rst_grant", req_ready, 4'b0001);
        e.ch  = 0;
        e.cnt = 1;
        sb.push_back(e);
        tick();
        req_valid = '0;
        collect();

        // Grants blocked while disabled.
        cfg_enable = 1'b0;
        req_valid  = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("dis_no_ready", req_ready, 0);
            chk("dis_idle", busy, 0);
        end
        req_valid  = '0;
        cfg_enable = 1'b1;
        tick();

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
